// File: rtl/pcie_cto_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cto_pkg
// Purpose  : Shared definitions for the PCIe completion-timeout tracker:
//            the per-tag state encoding, the four completion-timeout range
//            values (in timer ticks) and the select-to-range lookup.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcie_cto_pkg;

    // Lifecycle of one request tag.
    typedef enum logic [1:0] {
        TAG_IDLE    = 2'd0,
        TAG_ACTIVE  = 2'd1,
        TAG_EXPIRED = 2'd2
    } tag_state_e;

    // Width of the range constants; a tag timer must be at least this wide.
    localparam int RANGE_W = 16;

    localparam logic [RANGE_W-1:0] RANGE_SEL0 = 16'h1000;
    localparam logic [RANGE_W-1:0] RANGE_SEL1 = 16'h2000;
    localparam logic [RANGE_W-1:0] RANGE_SEL2 = 16'h4000;
    localparam logic [RANGE_W-1:0] RANGE_SEL3 = 16'h8000;

    // Map the 2-bit timeout_select code onto a tick count.
    function automatic logic [RANGE_W-1:0] range_ticks(input logic [1:0] sel);
        logic [RANGE_W-1:0] ticks;
        case (sel)
            2'd0:    ticks = RANGE_SEL0;
            2'd1:    ticks = RANGE_SEL1;
            2'd2:    ticks = RANGE_SEL2;
            default: ticks = RANGE_SEL3;
        endcase
        return ticks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_cto_tag_timer.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cto_tag_timer
// Purpose  : State and countdown timer for a single request tag.
//            IDLE -> ACTIVE on alloc (timer loaded from sel),
//            ACTIVE -> IDLE on cpl_free, ACTIVE -> EXPIRED when a tick
//            arrives with the timer at 1, EXPIRED -> IDLE on rpt_ack.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            alloc        - this tag is granted to a new request this cycle
//            sel          - timeout range select, sampled with alloc
//            tick         - prescaled timer tick
//            cpl_free     - final completion addressed to this tag
//            rpt_ack      - this tag's timeout report was accepted
//            state        - current tag state (tag_state_e encoding)
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cto_tag_timer
    import pcie_cto_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc,
    input  logic [1:0] sel,
    input  logic       tick,
    input  logic       cpl_free,
    input  logic       rpt_ack,
    output logic [1:0] state
);

    tag_state_e       r_state;
    tag_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TAG_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            TAG_IDLE: begin
                if (alloc) begin
                    w_state_nxt = TAG_ACTIVE;
                    w_timer_nxt = CNT_W'(range_ticks(sel));
                end
            end
            TAG_ACTIVE: begin
                // The final completion is checked before the tick so that a
                // completion landing on the expiry cycle frees the tag
                // instead of producing a spurious timeout report.
                if (cpl_free) begin
                    w_state_nxt = TAG_IDLE;
                    w_timer_nxt = '0;
                end else if (tick) begin
                    if (r_timer == CNT_W'(1)) begin
                        w_state_nxt = TAG_EXPIRED;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - CNT_W'(1);
                    end
                end
            end
            TAG_EXPIRED: begin
                // Only the report acceptance releases an expired tag; late
                // completions are flagged at the top level but ignored here.
                if (rpt_ack) begin
                    w_state_nxt = TAG_IDLE;
                end
            end
            default: begin
                w_state_nxt = TAG_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/pcie_cpl_timeout_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cpl_timeout_tracker
// Purpose  : Allocates tags to outstanding PCIe non-posted requests, runs a
//            per-tag completion timeout and reports expired tags.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            timeout_select   - range select sampled for the granted tag
//            req_valid/ready  - tag request handshake
//            req_tag          - lowest free tag (valid with req_ready)
//            cpl_valid/tag/last - completion notification from RX routing
//            to_valid/tag/ready - timeout report handshake (lowest expired)
//            unexp_cpl        - registered pulse: completion to IDLE/EXPIRED
//            outstanding      - registered count of non-IDLE tags
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cpl_timeout_tracker
    import pcie_cto_pkg::*;
#(
    parameter int NUM_TAGS = 8,
    parameter int TAG_W    = 3,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       timeout_select,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [TAG_W-1:0] req_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic             cpl_last,
    output logic             to_valid,
    output logic [TAG_W-1:0] to_tag,
    input  logic             to_ready,
    output logic             unexp_cpl,
    output logic [TAG_W:0]   outstanding
);

    localparam int OUT_W = TAG_W + 1;

    logic                w_tick;
    logic [1:0]          w_state [NUM_TAGS];
    logic [NUM_TAGS-1:0] w_idle;
    logic [NUM_TAGS-1:0] w_active;
    logic [NUM_TAGS-1:0] w_expired;
    logic [NUM_TAGS-1:0] w_alloc;
    logic [NUM_TAGS-1:0] w_cpl_free;
    logic [NUM_TAGS-1:0] w_rpt_ack;
    logic [TAG_W-1:0]    w_req_tag;
    logic [TAG_W-1:0]    w_to_tag;
    logic                w_req_ready;
    logic                w_to_valid;
    logic                w_fire;
    logic [OUT_W-1:0]    w_busy_count;
    logic                r_unexp_cpl;
    logic [OUT_W-1:0]    r_outstanding;

    // ------------------------------------------------------------------
    // Free-running tick prescaler: ticks on the cycle it wraps.
    // ------------------------------------------------------------------
    generate
        if (TICK_DIV <= 1) begin : g_tick_every_cycle
            assign w_tick = 1'b1;
        end else begin : g_tick_prescaler
            localparam int PRE_W = $clog2(TICK_DIV);
            localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

            logic [PRE_W-1:0] r_prescale;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prescale <= '0;
                end else if (r_prescale == PRE_LAST) begin
                    r_prescale <= '0;
                end else begin
                    r_prescale <= r_prescale + PRE_W'(1);
                end
            end

            assign w_tick = (r_prescale == PRE_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-tag state machines and their decoded control strobes.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
            assign w_idle[gi]     = (w_state[gi] == TAG_IDLE);
            assign w_active[gi]   = (w_state[gi] == TAG_ACTIVE);
            assign w_expired[gi]  = (w_state[gi] == TAG_EXPIRED);
            assign w_alloc[gi]    = w_fire & (w_req_tag == TAG_W'(gi));
            assign w_cpl_free[gi] = cpl_valid & cpl_last & (cpl_tag == TAG_W'(gi));
            assign w_rpt_ack[gi]  = w_to_valid & to_ready & (w_to_tag == TAG_W'(gi));

            pcie_cto_tag_timer #(
                .CNT_W (CNT_W)
            ) u_tag_timer (
                .clk      (clk),
                .rst_n    (rst_n),
                .alloc    (w_alloc[gi]),
                .sel      (timeout_select),
                .tick     (w_tick),
                .cpl_free (w_cpl_free[gi]),
                .rpt_ack  (w_rpt_ack[gi]),
                .state    (w_state[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lowest-index priority encoders for the free tag and the expired tag.
    // Scanning downward lets the lowest matching index be written last.
    // Both read registered tag state only, so a tag released this cycle
    // becomes visible to allocation on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_req_tag = '0;
        w_to_tag  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (w_idle[i]) begin
                w_req_tag = TAG_W'(i);
            end
            if (w_expired[i]) begin
                w_to_tag = TAG_W'(i);
            end
        end
    end

    assign w_req_ready = |w_idle;
    assign w_to_valid  = |w_expired;
    assign w_fire      = req_valid & w_req_ready;

    // ------------------------------------------------------------------
    // Population count of tags that are not IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!w_idle[i]) begin
                w_busy_count = w_busy_count + OUT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered status outputs. A completion aimed at a tag that is not
    // waiting for one (IDLE or already EXPIRED) is flagged a cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unexp_cpl   <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_unexp_cpl   <= cpl_valid & ~w_active[cpl_tag];
            r_outstanding <= w_busy_count;
        end
    end

    assign req_ready   = w_req_ready;
    assign req_tag     = w_req_tag;
    assign to_valid    = w_to_valid;
    assign to_tag      = w_to_tag;
    assign unexp_cpl   = r_unexp_cpl;
    assign outstanding = r_outstanding;

endmodule
`default_nettype wire
